// File: rtl/phase_sequencer_if.sv
// Handshake bundle between the processor control logic and the phase sequencer.
// The master side drives the run/halt/memory requests; the slave side (the
// sequencer) returns the one-hot phase strobes, status flags and retire count.
interface phase_sequencer_if #(
    parameter int CNT_W = 16
);
    logic             Run;
    logic             Halt;
    logic             Resume;
    logic             MemReq;
    logic             MemReady;
    logic             T0;
    logic             T1;
    logic             T2;
    logic             T3;
    logic             T4;
    logic             PCenable;
    logic             Busy;
    logic             Halted;
    logic             Timeout;
    logic [CNT_W-1:0] InstrCount;

    modport master (
        output Run, Halt, Resume, MemReq, MemReady,
        input  T0, T1, T2, T3, T4, PCenable, Busy, Halted, Timeout, InstrCount
    );

    modport slave (
        input  Run, Halt, Resume, MemReq, MemReady,
        output T0, T1, T2, T3, T4, PCenable, Busy, Halted, Timeout, InstrCount
    );
endinterface

// File: rtl/phase_sequencer.sv
// Multi-cycle timing-phase controller for the 8-bit RISC core. Walks each
// instruction through T0..T4, stretches T2 with wait states while a memory or
// port access is outstanding, retires the instruction with a one-cycle PC
// enable in T4, and parks in HALTED on HLT or on a wait-state timeout.
// Every output is decoded from registered state only.
module phase_sequencer #(
    parameter int WAIT_MAX = 16,
    parameter int CNT_W    = 16
) (
    input  logic               clk,
    input  logic               Reset,
    phase_sequencer_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE,
        S_T0,
        S_T1,
        S_T2,
        WAIT,
        S_T3,
        S_T4,
        HALTED
    } state_t;

    // Last wait-counter value before the sequencer gives up on the access.
    localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

    state_t           state;
    state_t           nextState;
    logic [7:0]       waitCnt;
    logic             timeoutFlag;
    logic [CNT_W-1:0] instrCount;

    logic             enterWait;
    logic             stayWait;
    logic             setTimeout;
    logic             retire;

    // Next-state selection plus one-cycle control pulses for the counters.
    always_comb begin
        nextState  = state;
        enterWait  = 1'b0;
        stayWait   = 1'b0;
        setTimeout = 1'b0;
        retire     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.Run) nextState = S_T0;
            end
            S_T0: nextState = S_T1;
            S_T1: nextState = S_T2;
            S_T2: begin
                if (bus.MemReq && !bus.MemReady) begin
                    nextState = WAIT;
                    enterWait = 1'b1;
                end else begin
                    nextState = S_T3;
                end
            end
            WAIT: begin
                // A late MemReady still completes the access even on the last allowed cycle.
                if (bus.MemReady) begin
                    nextState = S_T3;
                end else if (waitCnt == WAIT_LAST) begin
                    nextState  = HALTED;
                    setTimeout = 1'b1;
                end else begin
                    stayWait = 1'b1;
                end
            end
            S_T3: nextState = S_T4;
            S_T4: begin
                retire = 1'b1;
                // Halt outranks Run so HLT always stops the core.
                if (bus.Halt)     nextState = HALTED;
                else if (bus.Run) nextState = S_T0;
                else              nextState = IDLE;
            end
            HALTED: begin
                if (bus.Resume) nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) state <= IDLE;
        else        state <= nextState;
    end

    // Wait-state counter, sticky timeout flag and retired-instruction count.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            waitCnt     <= 8'd0;
            timeoutFlag <= 1'b0;
            instrCount  <= '0;
        end else begin
            if (enterWait)     waitCnt <= 8'd0;
            else if (stayWait) waitCnt <= waitCnt + 8'd1;
            if (setTimeout) timeoutFlag <= 1'b1;
            if (retire)     instrCount  <= instrCount + CNT_W'(1);
        end
    end

    // Moore output decode; T2 is held through WAIT so memory strobes stay asserted.
    assign bus.T0         = (state == S_T0);
    assign bus.T1         = (state == S_T1);
    assign bus.T2         = (state == S_T2) || (state == WAIT);
    assign bus.T3         = (state == S_T3);
    assign bus.T4         = (state == S_T4);
    assign bus.PCenable   = (state == S_T4);
    assign bus.Busy       = (state != IDLE) && (state != HALTED);
    assign bus.Halted     = (state == HALTED);
    assign bus.Timeout    = timeoutFlag;
    assign bus.InstrCount = instrCount;

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer: phase rotation, wait-state stretching,
// timeout, halt/resume, Run drop mid-instruction, async reset and count wrap.
module tb_phase_sequencer;

    localparam int WAIT_MAX = 16;
    localparam int CNT_W    = 4;

    localparam logic [4:0] PNONE = 5'b00000;
    localparam logic [4:0] P0    = 5'b00001;
    localparam logic [4:0] P1    = 5'b00010;
    localparam logic [4:0] P2    = 5'b00100;
    localparam logic [4:0] P3    = 5'b01000;
    localparam logic [4:0] P4    = 5'b10000;

    logic clk;
    logic Reset;
    int   total;
    int   passed;
    int   failed;

    phase_sequencer_if #(.CNT_W(CNT_W)) bus ();

    phase_sequencer #(
        .WAIT_MAX (WAIT_MAX),
        .CNT_W    (CNT_W)
    ) dut (
        .clk   (clk),
        .Reset (Reset),
        .bus   (bus)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one cycle and settle 1 time unit past the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Compare all outputs at once: {T4..T0, PCenable, Busy, Halted, Timeout, InstrCount}.
    task automatic checkOut(input string tag, input logic [4:0] ph, input logic busy,
                            input logic hlt, input logic tmo, input logic [CNT_W-1:0] cnt);
        logic [9+CNT_W-1:0] obs;
        logic [9+CNT_W-1:0] want;
        obs  = {bus.T4, bus.T3, bus.T2, bus.T1, bus.T0, bus.PCenable, bus.Busy,
                bus.Halted, bus.Timeout, bus.InstrCount};
        want = {ph, ph[4], busy, hlt, tmo, cnt};
        total++;
        assert (obs === want) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %b required %b", tag, obs, want);
        end
    endtask

    initial begin
        total  = 0;
        passed = 0;
        failed = 0;
        Reset        = 1'b1;
        bus.Run      = 1'b0;
        bus.Halt     = 1'b0;
        bus.Resume   = 1'b0;
        bus.MemReq   = 1'b0;
        bus.MemReady = 1'b0;

        // Asynchronous reset takes effect between clock edges.
        #2 Reset = 1'b0;
        #1 checkOut("reset_async", PNONE, 0, 0, 0, 4'd0);
        step();
        checkOut("reset_hold", PNONE, 0, 0, 0, 4'd0);

        // Run held through reset release: T0 at the first edge, then 20 cycles of rotation.
        bus.Run = 1'b1;
        @(negedge clk);
        Reset = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            step();
            case ((i - 1) % 5)
                0: checkOut($sformatf("rot_c%0d", i), P0, 1, 0, 0, 4'((i - 1) / 5));
                1: checkOut($sformatf("rot_c%0d", i), P1, 1, 0, 0, 4'((i - 1) / 5));
                2: checkOut($sformatf("rot_c%0d", i), P2, 1, 0, 0, 4'((i - 1) / 5));
                3: checkOut($sformatf("rot_c%0d", i), P3, 1, 0, 0, 4'((i - 1) / 5));
                default: checkOut($sformatf("rot_c%0d", i), P4, 1, 0, 0, 4'((i - 1) / 5));
            endcase
        end
        bus.Run = 1'b0;
        step();
        checkOut("rot_idle", PNONE, 0, 0, 0, 4'd4);

        // Wait-state instruction: three WAIT cycles, MemReady on the third.
        bus.Run = 1'b1;
        step();
        checkOut("mem_t0", P0, 1, 0, 0, 4'd4);
        bus.Run    = 1'b0;
        bus.MemReq = 1'b1;
        step();
        checkOut("mem_t1", P1, 1, 0, 0, 4'd4);
        step();
        checkOut("mem_t2", P2, 1, 0, 0, 4'd4);
        step();
        checkOut("mem_w1", P2, 1, 0, 0, 4'd4);
        step();
        checkOut("mem_w2", P2, 1, 0, 0, 4'd4);
        step();
        checkOut("mem_w3", P2, 1, 0, 0, 4'd4);
        bus.MemReady = 1'b1;
        step();
        checkOut("mem_t3", P3, 1, 0, 0, 4'd4);
        bus.MemReq   = 1'b0;
        bus.MemReady = 1'b0;
        step();
        checkOut("mem_t4", P4, 1, 0, 0, 4'd4);
        step();
        checkOut("mem_idle", PNONE, 0, 0, 0, 4'd5);

        // Timeout: MemReady never arrives; 16 WAIT cycles then HALTED with Timeout.
        bus.Run = 1'b1;
        step();
        checkOut("to_t0", P0, 1, 0, 0, 4'd5);
        step();
        bus.MemReq = 1'b1;
        checkOut("to_t1", P1, 1, 0, 0, 4'd5);
        step();
        checkOut("to_t2", P2, 1, 0, 0, 4'd5);
        for (int i = 1; i <= WAIT_MAX; i++) begin
            step();
            checkOut($sformatf("to_w%0d", i), P2, 1, 0, 0, 4'd5);
        end
        step();
        checkOut("to_halted", PNONE, 0, 1, 1, 4'd5);
        step();
        checkOut("to_run_ignored", PNONE, 0, 1, 1, 4'd5);
        bus.Resume = 1'b1;
        bus.Run    = 1'b0;
        bus.MemReq = 1'b0;
        step();
        checkOut("to_resume", PNONE, 0, 0, 1, 4'd5);
        bus.Resume = 1'b0;
        step();
        checkOut("to_idle_sticky", PNONE, 0, 0, 1, 4'd5);

        // Halt and Run together in T4: Halt wins, count includes the halting instruction.
        bus.Run = 1'b1;
        step();
        checkOut("hlt_t0", P0, 1, 0, 1, 4'd5);
        step();
        step();
        checkOut("hlt_t2", P2, 1, 0, 1, 4'd5);
        step();
        step();
        checkOut("hlt_t4", P4, 1, 0, 1, 4'd5);
        bus.Halt = 1'b1;
        step();
        checkOut("hlt_halted", PNONE, 0, 1, 1, 4'd6);
        bus.Halt   = 1'b0;
        bus.Resume = 1'b1;
        step();
        checkOut("hlt_resume_idle", PNONE, 0, 0, 1, 4'd6);
        bus.Resume = 1'b0;
        step();
        checkOut("hlt_resume_t0", P0, 1, 0, 1, 4'd6);

        // Run dropped in T1: instruction completes, then IDLE.
        step();
        checkOut("drop_t1", P1, 1, 0, 1, 4'd6);
        bus.Run = 1'b0;
        step();
        checkOut("drop_t2", P2, 1, 0, 1, 4'd6);
        step();
        checkOut("drop_t3", P3, 1, 0, 1, 4'd6);
        step();
        checkOut("drop_t4", P4, 1, 0, 1, 4'd6);
        step();
        checkOut("drop_idle", PNONE, 0, 0, 1, 4'd7);

        // Reset pulsed mid-WAIT clears everything immediately.
        bus.Run = 1'b1;
        step();
        bus.Run    = 1'b0;
        bus.MemReq = 1'b1;
        step();
        step();
        step();
        step();
        checkOut("rst_in_wait", P2, 1, 0, 1, 4'd7);
        @(negedge clk);
        Reset = 1'b0;
        #1 checkOut("rst_mid_wait", PNONE, 0, 0, 0, 4'd0);
        step();
        checkOut("rst_mid_hold", PNONE, 0, 0, 0, 4'd0);
        bus.MemReq = 1'b0;
        bus.Run    = 1'b1;
        @(negedge clk);
        Reset = 1'b1;

        // 16 back-to-back retirements wrap the 4-bit count to zero.
        step();
        checkOut("wrap_t0", P0, 1, 0, 0, 4'd0);
        repeat (74) step();
        checkOut("wrap_t4_15", P4, 1, 0, 0, 4'd14);
        step();
        checkOut("wrap_cnt15", P0, 1, 0, 0, 4'd15);
        repeat (4) step();
        checkOut("wrap_t4_16", P4, 1, 0, 0, 4'd15);
        bus.Run = 1'b0;
        step();
        checkOut("wrap_zero", PNONE, 0, 0, 0, 4'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
